median_window_loader: RTL

- Upstream feeder for the 16-input, 13-bit sorting network of the median filter.
- Reads 8-bit pixels in raster order from a synchronous image ROM and builds one 4x4 neighbourhood per output pixel.
- Each neighbourhood is packed as sixteen 13-bit keys onto a 208-bit bus and handed to the sorter with a valid/ready handshake.
- Window columns slide horizontally, so each step fetches only one new column.

---
 rtl/median_window_loader.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/median_window_loader.sv
// median_window_loader: feeds 4x4 pixel neighbourhoods to the median sorting network.
// Reads 8-bit pixels from a synchronous image ROM in raster order. The first window of
// each row is loaded in full. Every later step fetches only the new rightmost column and
// slides the window left by one column.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               frame start pulse, ignored while busy
//   busy                frame in progress
//   ird, iaddr, idata   ROM read enable / address / data (data arrives one cycle after ird)
//   win_valid/ready     window handshake to the sorter
//   win_data            sixteen 13-bit keys {pixel, slot}, slot k at bits [13k+12:13k]
//   win_x, win_y        anchor coordinate of the presented window
//   done                one-cycle pulse after the last window is accepted
module median_window_loader #(
    parameter int unsigned IMG_W = 128,
    parameter int unsigned IMG_H = 128,
    parameter int unsigned AW    = 14,
    localparam int unsigned XW   = $clog2(IMG_W),
    localparam int unsigned YW   = $clog2(IMG_H)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          busy,
    output logic          ird,
    output logic [AW-1:0] iaddr,
    input  logic [7:0]    idata,
    output logic          win_valid,
    input  logic          win_ready,
    output logic [207:0]  win_data,
    output logic [XW-1:0] win_x,
    output logic [YW-1:0] win_y,
    output logic          done
);

    typedef enum logic [2:0] {StIdle, StPrime, StEmit, StFetch, StShift, StDone} state_e;

    state_e        state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [4:0]    cnt_q, cnt_d;
    logic [AW-1:0] iaddr_q, iaddr_d;
    logic [7:0]    pix_q [16];
    logic [7:0]    pix_d [16];
    logic [7:0]    stg_q [4];
    logic [7:0]    stg_d [4];

    // Pending capture: the slot addressed last cycle is written when idata is valid.
    logic          cap_en_q, cap_en_d;
    logic          cap_rd_q, cap_rd_d;
    logic          cap_stg_q, cap_stg_d;
    logic [3:0]    cap_idx_q, cap_idx_d;

    logic          slot_act;
    logic          to_stg;
    logic [3:0]    slot_idx;
    int            rd_col;
    int            rd_row;
    logic          in_rng;
    logic [7:0]    cap_val;

    // Control: state, coordinates, slot counter and ROM request
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        cnt_d     = cnt_q;
        slot_act  = 1'b0;
        to_stg    = 1'b0;
        slot_idx  = '0;
        rd_col    = 0;
        rd_row    = 0;
        win_valid = 1'b0;
        done      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    x_d     = '0;
                    y_d     = '0;
                    cnt_d   = '0;
                    state_d = StPrime;
                end
            end
            StPrime: begin
                // Column-major walk: cnt[3:2] is the column, cnt[1:0] the row; 16 is drain.
                if (cnt_q == 5'd16) begin
                    state_d = StEmit;
                end else begin
                    slot_act = 1'b1;
                    slot_idx = {cnt_q[1:0], cnt_q[3:2]};
                    rd_col   = int'(x_q) - 1 + int'(cnt_q[3:2]);
                    rd_row   = int'(y_q) - 1 + int'(cnt_q[1:0]);
                    cnt_d    = cnt_q + 5'd1;
                end
            end
            StEmit: begin
                win_valid = 1'b1;
                if (win_ready) begin
                    cnt_d = '0;
                    if (x_q == XW'(IMG_W - 1)) begin
                        if (y_q == YW'(IMG_H - 1)) begin
                            state_d = StDone;
                        end else begin
                            x_d     = '0;
                            y_d     = y_q + YW'(1);
                            state_d = StPrime;
                        end
                    end else begin
                        x_d     = x_q + XW'(1);
                        state_d = StFetch;
                    end
                end
            end
            StFetch: begin
                // x has already advanced, so the new right column is x+2.
                if (cnt_q == 5'd4) begin
                    state_d = StShift;
                end else begin
                    slot_act = 1'b1;
                    to_stg   = 1'b1;
                    slot_idx = {2'b00, cnt_q[1:0]};
                    rd_col   = int'(x_q) + 2;
                    rd_row   = int'(y_q) - 1 + int'(cnt_q[1:0]);
                    cnt_d    = cnt_q + 5'd1;
                end
            end
            StShift: begin
                state_d = StEmit;
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        in_rng  = (rd_col >= 0) && (rd_col < int'(IMG_W)) &&
                  (rd_row >= 0) && (rd_row < int'(IMG_H));
        ird     = slot_act && in_rng;
        iaddr_d = ird ? AW'(rd_row * int'(IMG_W) + rd_col) : iaddr_q;

        cap_en_d  = slot_act;
        cap_rd_d  = ird;
        cap_stg_d = to_stg;
        cap_idx_d = slot_idx;
    end

    assign iaddr = iaddr_d;
    assign busy  = (state_q != StIdle) && (state_q != StDone);
    assign win_x = x_q;
    assign win_y = y_q;

    // Datapath: window and staging column updates
    always_comb begin
        pix_d   = pix_q;
        stg_d   = stg_q;
        cap_val = 8'h00;

        // Out-of-image slots are written with zero, not with whatever idata carries.
        if (cap_en_q) begin
            cap_val = cap_rd_q ? idata : 8'h00;
            if (cap_stg_q) begin
                stg_d[cap_idx_q[1:0]] = cap_val;
            end else begin
                pix_d[cap_idx_q] = cap_val;
            end
        end

        if (state_q == StShift) begin
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 3; c++) begin
                    pix_d[4*r + c] = pix_q[4*r + c + 1];
                end
                pix_d[4*r + 3] = stg_q[r];
            end
        end
    end

    // Keys are built from slot position, so shifted pixels pick up their new slot index.
    always_comb begin
        win_data = '0;
        if (state_q == StEmit) begin
            for (int k = 0; k < 16; k++) begin
                win_data[13*k +: 13] = {pix_q[k], 5'(k)};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            x_q       <= '0;
            y_q       <= '0;
            cnt_q     <= '0;
            iaddr_q   <= '0;
            cap_en_q  <= 1'b0;
            cap_rd_q  <= 1'b0;
            cap_stg_q <= 1'b0;
            cap_idx_q <= '0;
            for (int i = 0; i < 16; i++) begin
                pix_q[i] <= '0;
            end
            for (int i = 0; i < 4; i++) begin
                stg_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            cnt_q     <= cnt_d;
            iaddr_q   <= iaddr_d;
            cap_en_q  <= cap_en_d;
            cap_rd_q  <= cap_rd_d;
            cap_stg_q <= cap_stg_d;
            cap_idx_q <= cap_idx_d;
            pix_q     <= pix_d;
            stg_q     <= stg_d;
        end
    end

endmodule
